tick_scheduler: RTL and testbench

- Timebase controller for the clock/alarm design.
- Derives one-cycle tick enables from the 50 MHz board clock under run, pause, fast-set and single-step control.
- Supports a runtime-reloadable divisor through a valid/ready handshake.
- Downstream time, alarm and display blocks consume `tick` as a clock enable; they do not use a derived clock.

---
 rtl/tick_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_tick_scheduler.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_scheduler.sv
// tick_scheduler: timebase controller for the clock/alarm design.
// Produces one-cycle tick enables from clk_50MHz in STOP / RUN / FAST modes,
// with single-step while stopped and a runtime-reloadable normal divisor
// offered through a valid/ready handshake.
//
// Handshake: a divisor transfer happens on a rising edge where
// cfg_valid && cfg_ready are both high. cfg_ready stays low while a divisor
// is pending; a source seeing cfg_ready=0 must hold cfg_valid and cfg_div
// stable until it is taken.
//
// Optional feature: define TICK_SCHEDULER_TICK_CNT_EN to add the 16-bit
// tick_cnt output (wrapping count of emitted ticks, not cleared on STOP).
module tick_scheduler #(
    parameter int CLK_HZ  = 50000000,
    parameter int TICK_HZ = 1,
    parameter int FAST_HZ = 8,
    parameter int DIV_W   = 26
) (
    input  logic             clk_50MHz,
    input  logic             rst,
    input  logic             run,
    input  logic             fast,
    input  logic             step,
    input  logic             cfg_valid,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             tick,
    output logic             phase,
`ifdef TICK_SCHEDULER_TICK_CNT_EN
    output logic [1:0]       mode,
    output logic [15:0]      tick_cnt
`else
    output logic [1:0]       mode
`endif
);

    // Divisors are "cycles per tick minus one", fixed at elaboration.
    localparam int NORM_DIV_INT = CLK_HZ / TICK_HZ - 1;
    localparam int FAST_DIV_INT = CLK_HZ / FAST_HZ - 1;
    localparam logic [DIV_W-1:0] NORM_DIV = NORM_DIV_INT[DIV_W-1:0];
    localparam logic [DIV_W-1:0] FAST_DIV = FAST_DIV_INT[DIV_W-1:0];

    if ((NORM_DIV_INT >> DIV_W) != 0) begin : g_div_w_too_small
        $error("tick_scheduler: DIV_W too narrow for CLK_HZ/TICK_HZ-1");
    end
    if (FAST_HZ < TICK_HZ) begin : g_fast_too_slow
        $error("tick_scheduler: FAST_HZ must not be below TICK_HZ");
    end

    typedef enum logic [1:0] {
        S_STOP = 2'd0,
        S_RUN  = 2'd1,
        S_FAST = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] pend_div_q, pend_div_d;
    logic             pend_q, pend_d;
    logic             tick_q, tick_d;
    logic             phase_q, phase_d;

    logic             accept;
    logic             apply;
    logic [DIV_W-1:0] run_reload_div;

    // State, counter and divisor registers; reset overrides everything.
    always_ff @(posedge clk_50MHz) begin
        if (rst) begin
            state_q    <= S_STOP;
            cnt_q      <= '0;
            div_q      <= NORM_DIV;
            pend_div_q <= '0;
            pend_q     <= 1'b0;
            tick_q     <= 1'b0;
            phase_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            pend_div_q <= pend_div_d;
            pend_q     <= pend_d;
            tick_q     <= tick_d;
            phase_q    <= phase_d;
        end
    end

    // Next state, counter reload/decrement, tick generation and divisor apply.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        pend_div_d = pend_div_q;
        pend_d     = pend_q;
        tick_d     = 1'b0;
        apply      = 1'b0;

        // A pending divisor replaces the normal one at the next RUN reload.
        run_reload_div = pend_q ? pend_div_q : div_q;
        accept         = cfg_valid && !pend_q;

        if (!run) begin
            state_d = S_STOP;
        end else if (fast) begin
            state_d = S_FAST;
        end else begin
            state_d = S_RUN;
        end

        // While stopped, a pending divisor lands one cycle after acceptance.
        if (state_q == S_STOP && pend_q) begin
            apply = 1'b1;
        end

        if (state_d == S_STOP) begin
            // Entering or staying in STOP drops the count; a cnt==0 in
            // the same cycle is discarded. Only step produces a tick here.
            cnt_d  = '0;
            tick_d = (state_q == S_STOP) && step;
        end else if (state_d != state_q) begin
            // Mode entry or RUN<->FAST switch: reload for the new mode.
            // A count expiring on the switch cycle still yields its tick.
            tick_d = (state_q != S_STOP) && (cnt_q == '0);
            if (state_d == S_FAST) begin
                cnt_d = FAST_DIV;
            end else begin
                cnt_d = run_reload_div;
                if (pend_q) begin
                    apply = 1'b1;
                end
            end
        end else if (cnt_q == '0) begin
            tick_d = 1'b1;
            if (state_q == S_FAST) begin
                cnt_d = FAST_DIV;
            end else begin
                cnt_d = run_reload_div;
                if (pend_q) begin
                    apply = 1'b1;
                end
            end
        end else begin
            cnt_d = cnt_q - DIV_W'(1);
        end

        if (apply) begin
            div_d  = pend_div_q;
            pend_d = 1'b0;
        end
        // accept needs pend_q=0 and apply needs pend_q=1, so they never collide.
        if (accept) begin
            pend_div_d = cfg_div;
            pend_d     = 1'b1;
        end

        phase_d = phase_q ^ tick_d;
    end

    assign tick      = tick_q;
    assign phase     = phase_q;
    assign mode      = state_q;
    assign cfg_ready = ~pend_q;

`ifdef TICK_SCHEDULER_TICK_CNT_EN
    logic [15:0] tick_cnt_q;

    // Running count of emitted ticks; wraps naturally and survives STOP.
    always_ff @(posedge clk_50MHz) begin
        if (rst) begin
            tick_cnt_q <= '0;
        end else if (tick_q) begin
            tick_cnt_q <= tick_cnt_q + 16'd1;
        end
    end

    assign tick_cnt = tick_cnt_q;
`endif

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler with CLK_HZ=20, TICK_HZ=1, FAST_HZ=4,
// DIV_W=5 (normal divisor 19, fast divisor 4). Define
// TICK_SCHEDULER_TICK_CNT_EN to also exercise the tick_cnt wrap.
module tb_tick_scheduler;

  localparam int DIV_W = 5;

  logic             clk_50MHz = 1'b0;
  logic             rst = 1'b1;
  logic             run = 1'b0;
  logic             fast = 1'b0;
  logic             step = 1'b0;
  logic             cfg_valid = 1'b0;
  logic [DIV_W-1:0] cfg_div = '0;
  logic             cfg_ready;
  logic             tick;
  logic             phase;
  logic [1:0]       mode;
`ifdef TICK_SCHEDULER_TICK_CNT_EN
  logic [15:0]      tick_cnt;
`endif

  int total = 0;
  int bad = 0;
  logic exp_phase = 1'b0;

  tick_scheduler #(
    .CLK_HZ (20),
    .TICK_HZ(1),
    .FAST_HZ(4),
    .DIV_W  (DIV_W)
  ) dut (
    .clk_50MHz(clk_50MHz),
    .rst      (rst),
    .run      (run),
    .fast     (fast),
    .step     (step),
    .cfg_valid(cfg_valid),
    .cfg_div  (cfg_div),
    .cfg_ready(cfg_ready),
    .tick     (tick),
    .phase    (phase),
`ifdef TICK_SCHEDULER_TICK_CNT_EN
    .mode     (mode),
    .tick_cnt (tick_cnt)
`else
    .mode     (mode)
`endif
  );

  always #5 clk_50MHz = ~clk_50MHz;

  // Advance one clock; outputs are observed 1 time unit after the edge.
  task automatic step_clk();
    @(posedge clk_50MHz);
    #1;
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step_clk();
  endtask

  // Cycles until tick is seen high; -1 if it never shows within max_cycles.
  task automatic wait_tick(input int max_cycles, output int n);
    n = 0;
    do begin
      step_clk();
      n++;
    end while (tick !== 1'b1 && n < max_cycles);
    if (tick !== 1'b1) n = -1;
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    run = 1'b0;
    fast = 1'b0;
    step = 1'b0;
    cfg_valid = 1'b0;
    step_n(2);
    exp_phase = 1'b0;
    total++; if (mode !== 2'd0) begin bad++; $display("FAIL reset_mode: got %0d want 0", mode); end
    total++; if (tick !== 1'b0) begin bad++; $display("FAIL reset_tick: got %0b want 0", tick); end
    total++; if (phase !== 1'b0) begin bad++; $display("FAIL reset_phase: got %0b want 0", phase); end
    total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL reset_cfg_ready: got %0b want 1", cfg_ready); end
    rst = 1'b0;
  endtask

  task automatic test_run();
    int n;
    run = 1'b1;
    step_clk();
    total++; if (mode !== 2'd1) begin bad++; $display("FAIL run_mode: got %0d want 1", mode); end
    wait_tick(40, n);
    exp_phase = ~exp_phase;
    total++; if (n !== 20) begin bad++; $display("FAIL run_first_tick: got %0d cycles want 20 after entry", n); end
    total++; if (phase !== exp_phase) begin bad++; $display("FAIL run_phase1: got %0b want %0b", phase, exp_phase); end
    step_clk();
    total++; if (tick !== 1'b0) begin bad++; $display("FAIL run_tick_width: got %0b want 0", tick); end
    wait_tick(40, n);
    exp_phase = ~exp_phase;
    total++; if (n !== 19) begin bad++; $display("FAIL run_period: got %0d want 19 more cycles", n); end
    total++; if (phase !== exp_phase) begin bad++; $display("FAIL run_phase2: got %0b want %0b", phase, exp_phase); end
  endtask

  task automatic test_fast();
    int n;
    step_n(7);
    fast = 1'b1;
    step_clk();
    total++; if (mode !== 2'd2) begin bad++; $display("FAIL fast_mode: got %0d want 2", mode); end
    wait_tick(40, n);
    exp_phase = ~exp_phase;
    total++; if (n !== 5) begin bad++; $display("FAIL fast_first_tick: got %0d want 5", n); end
    total++; if (phase !== exp_phase) begin bad++; $display("FAIL fast_phase: got %0b want %0b", phase, exp_phase); end
    wait_tick(40, n);
    exp_phase = ~exp_phase;
    total++; if (n !== 5) begin bad++; $display("FAIL fast_period: got %0d want 5", n); end
    fast = 1'b0;
    step_clk();
    total++; if (mode !== 2'd1) begin bad++; $display("FAIL fast_exit_mode: got %0d want 1", mode); end
    wait_tick(40, n);
    exp_phase = ~exp_phase;
    total++; if (n !== 20) begin bad++; $display("FAIL fast_exit_period: got %0d want 20", n); end
  endtask

  // Switch to FAST on the very cycle the RUN count expires.
  task automatic test_switch_pending();
    int n;
    step_n(19);
    fast = 1'b1;
    step_clk();
    exp_phase = ~exp_phase;
    total++; if (tick !== 1'b1) begin bad++; $display("FAIL switch_pending_tick: got %0b want 1", tick); end
    total++; if (mode !== 2'd2) begin bad++; $display("FAIL switch_pending_mode: got %0d want 2", mode); end
    wait_tick(40, n);
    exp_phase = ~exp_phase;
    total++; if (n !== 5) begin bad++; $display("FAIL switch_pending_next: got %0d want 5", n); end
    fast = 1'b0;
    step_clk();
    wait_tick(40, n);
    exp_phase = ~exp_phase;
    total++; if (n !== 20) begin bad++; $display("FAIL switch_back_period: got %0d want 20", n); end
    total++; if (phase !== exp_phase) begin bad++; $display("FAIL switch_phase: got %0b want %0b", phase, exp_phase); end
  endtask

  task automatic test_stop_step();
    int n;
    int seen;
    step_n(19);
    run = 1'b0;
    step_clk();
    total++; if (tick !== 1'b0) begin bad++; $display("FAIL stop_drop_tick: got %0b want 0", tick); end
    total++; if (mode !== 2'd0) begin bad++; $display("FAIL stop_mode: got %0d want 0", mode); end
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      step_clk();
      if (tick === 1'b1) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL stop_idle_ticks: got %0d want 0", seen); end
    step = 1'b1;
    step_clk();
    step = 1'b0;
    exp_phase = ~exp_phase;
    total++; if (tick !== 1'b1) begin bad++; $display("FAIL step_tick: got %0b want 1", tick); end
    total++; if (phase !== exp_phase) begin bad++; $display("FAIL step_phase: got %0b want %0b", phase, exp_phase); end
    step_clk();
    total++; if (tick !== 1'b0) begin bad++; $display("FAIL step_single: got %0b want 0", tick); end
    run = 1'b1;
    step = 1'b1;
    step_clk();
    step = 1'b0;
    total++; if (tick !== 1'b0) begin bad++; $display("FAIL step_on_entry: got %0b want 0", tick); end
    step = 1'b1;
    step_clk();
    step = 1'b0;
    total++; if (tick !== 1'b0) begin bad++; $display("FAIL step_in_run: got %0b want 0", tick); end
    wait_tick(40, n);
    exp_phase = ~exp_phase;
    total++; if (n !== 19) begin bad++; $display("FAIL step_run_period: got %0d want 19", n); end
  endtask

  task automatic test_cfg_run();
    int n;
    step_n(3);
    cfg_valid = 1'b1;
    cfg_div = 5'd9;
    step_clk();
    total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL cfg_accept_ready: got %0b want 0", cfg_ready); end
    cfg_div = 5'd3;
    wait_tick(40, n);
    exp_phase = ~exp_phase;
    total++; if (n !== 16) begin bad++; $display("FAIL cfg_old_period: got %0d want 16", n); end
    total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL cfg_ready_after_apply: got %0b want 1", cfg_ready); end
    step_clk();
    cfg_valid = 1'b0;
    total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL cfg_held_accept: got %0b want 0", cfg_ready); end
    wait_tick(40, n);
    exp_phase = ~exp_phase;
    total++; if (n !== 9) begin bad++; $display("FAIL cfg_new_period: got %0d want 9", n); end
    total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL cfg_ready_second: got %0b want 1", cfg_ready); end
    wait_tick(40, n);
    exp_phase = ~exp_phase;
    total++; if (n !== 4) begin bad++; $display("FAIL cfg_second_period: got %0d want 4", n); end
    wait_tick(40, n);
    exp_phase = ~exp_phase;
    total++; if (n !== 4) begin bad++; $display("FAIL cfg_second_repeat: got %0d want 4", n); end
  endtask

  task automatic test_reset_fast();
    int n;
    fast = 1'b1;
    step_n(3);
    rst = 1'b1;
    step_clk();
    exp_phase = 1'b0;
    total++; if (mode !== 2'd0) begin bad++; $display("FAIL rstfast_mode: got %0d want 0", mode); end
    total++; if (tick !== 1'b0) begin bad++; $display("FAIL rstfast_tick: got %0b want 0", tick); end
    total++; if (phase !== 1'b0) begin bad++; $display("FAIL rstfast_phase: got %0b want 0", phase); end
    total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL rstfast_cfg_ready: got %0b want 1", cfg_ready); end
    rst = 1'b0;
    fast = 1'b0;
    step_clk();
    wait_tick(40, n);
    exp_phase = ~exp_phase;
    total++; if (n !== 20) begin bad++; $display("FAIL rstfast_div_restored: got %0d want 20", n); end
    total++; if (phase !== exp_phase) begin bad++; $display("FAIL rstfast_phase_after: got %0b want %0b", phase, exp_phase); end
  endtask

  task automatic test_cfg_stop();
    int n;
    int seen;
    run = 1'b0;
    step_clk();
    cfg_valid = 1'b1;
    cfg_div = 5'd2;
    step_clk();
    cfg_valid = 1'b0;
    total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL stopcfg_accept: got %0b want 0", cfg_ready); end
    step_clk();
    total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL stopcfg_apply: got %0b want 1", cfg_ready); end
    run = 1'b1;
    step_clk();
    wait_tick(40, n);
    total++; if (n !== 3) begin bad++; $display("FAIL stopcfg_first: got %0d want 3", n); end
    wait_tick(40, n);
    total++; if (n !== 3) begin bad++; $display("FAIL stopcfg_period: got %0d want 3", n); end
    run = 1'b0;
    step_clk();
    cfg_valid = 1'b1;
    cfg_div = 5'd0;
    step_clk();
    cfg_valid = 1'b0;
    step_clk();
    run = 1'b1;
    step_clk();
    wait_tick(40, n);
    total++; if (n !== 1) begin bad++; $display("FAIL div0_first: got %0d want 1", n); end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      step_clk();
      if (tick === 1'b1) seen++;
    end
    total++; if (seen !== 8) begin bad++; $display("FAIL div0_every_cycle: got %0d ticks want 8", seen); end
  endtask

`ifdef TICK_SCHEDULER_TICK_CNT_EN
  task automatic test_tick_cnt();
    rst = 1'b1;
    run = 1'b0;
    fast = 1'b0;
    step_n(2);
    rst = 1'b0;
    total++; if (tick_cnt !== 16'd0) begin bad++; $display("FAIL tick_cnt_reset: got %0d want 0", tick_cnt); end
    cfg_valid = 1'b1;
    cfg_div = 5'd0;
    step_clk();
    cfg_valid = 1'b0;
    step_clk();
    run = 1'b1;
    step_clk();
    for (int k = 1; k <= 65537; k++) begin
      step_clk();
      if (k == 10) begin
        total++; if (tick_cnt !== 16'd9) begin bad++; $display("FAIL tick_cnt_early: got %0d want 9", tick_cnt); end
      end
      if (k == 65536) begin
        total++; if (tick_cnt !== 16'd65535) begin bad++; $display("FAIL tick_cnt_max: got %0d want 65535", tick_cnt); end
      end
      if (k == 65537) begin
        total++; if (tick_cnt !== 16'd0) begin bad++; $display("FAIL tick_cnt_wrap: got %0d want 0", tick_cnt); end
        total++; if (tick !== 1'b1) begin bad++; $display("FAIL tick_cnt_stream: got %0b want 1", tick); end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_run();
    test_fast();
    test_switch_pending();
    test_stop_step();
    test_cfg_run();
    test_reset_fast();
    test_cfg_stop();
`ifdef TICK_SCHEDULER_TICK_CNT_EN
    test_tick_cnt();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
